// File: rtl/nfc_flash_responder.sv
// rtl/nfc_flash_responder.sv - NAND-flash responder model for one NFC flash port
// Purpose: decodes command/address/data bus cycles strobed by the NFC controller,
//   holds a PAGES x PAGE_BYTES array, serves page reads and page programs and
//   drives ready/busy.
// Optional feature: define NFC_STATUS_EN to build the 70h read-status command.
// Ports:
//   clk          in   single clock, all strobes sampled on posedge
//   rst          in   asynchronous active-low reset
//   F_IO_IN      in   [7:0] bus value from controller
//   F_IO_OUT     out  [7:0] read data / status byte
//   F_IO_OE      out  1 = responder drives the bus
//   F_CLE/F_ALE  in   command / address latch enable
//   F_REN/F_WEN  in   read / write strobe, active low
//   F_RB         out  ready(1) / busy(0)
module nfc_flash_responder #(
   parameter int PAGE_BYTES = 512,
   parameter int PAGES      = 64,
   parameter int T_R_CYC    = 25,
   parameter int T_PROG_CYC = 600,
   parameter int T_RST_CYC  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] F_IO_IN,
   output logic [7:0] F_IO_OUT,
   output logic       F_IO_OE,
   input  logic       F_CLE,
   input  logic       F_ALE,
   input  logic       F_REN,
   input  logic       F_WEN,
   output logic       F_RB
);
   localparam int CW    = $clog2(PAGE_BYTES);
   localparam int RW    = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int T_MAX = (T_PROG_CYC > T_R_CYC)
                        ? ((T_PROG_CYC > T_RST_CYC) ? T_PROG_CYC : T_RST_CYC)
                        : ((T_R_CYC > T_RST_CYC) ? T_R_CYC : T_RST_CYC);
   localparam int TW    = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_RD_BUSY, ST_RD_DATA, ST_PG_DATA, ST_PG_BUSY, ST_RST_BUSY
   } state_t;

   state_t          state, next_state;
   logic [7:0]      io_s;
   logic            cle_s, ale_s, wen_s, wen_p, ren_s, ren_p;
   logic [TW-1:0]   cnt, cnt_last;
   logic [CW-1:0]   col;
   logic            col_hi;
   logic [RW-1:0]   row;
   logic [1:0]      addr_cnt;
   logic            is_prog;
   logic [7:0]      io_out;
   logic            oe;
   logic [PAGE_BYTES-1:0] buf_vld;
   logic [7:0]      buf_dat [PAGE_BYTES];
   // Array is stored inverted: a zero-initialised RAM reads back as erased FFh,
   // and rst never touches it so contents survive a reset.
   logic [7:0]      mem_n [PAGES*PAGE_BYTES];

   logic wen_rise, ren_fall, ren_rise;
   logic cmd_cyc, addr_cyc, data_cyc, cmd_ff, busy, copy_en;
   logic [CW-1:0] cp_idx;
   logic [7:0]    prog_byte, rd_byte;

   assign wen_rise = wen_s & ~wen_p;
   assign ren_fall = ~ren_s & ren_p;
   assign ren_rise = ren_s & ~ren_p;
   assign cmd_cyc  = wen_rise & cle_s & ~ale_s;
   assign addr_cyc = wen_rise & ale_s & ~cle_s;
   assign data_cyc = wen_rise & ~cle_s & ~ale_s;
   assign cmd_ff   = cmd_cyc && (io_s == 8'hFF);
   assign busy     = (state == ST_RD_BUSY) || (state == ST_PG_BUSY) || (state == ST_RST_BUSY);

   // Program copy walks one byte per busy clk; an FFh abort suppresses the
   // byte of the cycle it lands in.
   assign cp_idx    = cnt[CW-1:0];
   assign copy_en   = (state == ST_PG_BUSY) && (cnt < TW'(PAGE_BYTES)) && !cmd_ff;
   assign prog_byte = buf_vld[cp_idx] ? buf_dat[cp_idx] : 8'hFF;
   assign rd_byte   = ~mem_n[{row, col}];

   assign F_RB     = ~busy;
   assign F_IO_OUT = io_out;
   assign F_IO_OE  = oe;

`ifdef NFC_STATUS_EN
   logic       status_q, fail;
   logic [7:0] status_byte;
   assign status_byte = {1'b1, F_RB, 5'b0, fail};
`endif

   always_comb begin
      cnt_last = TW'(T_RST_CYC - 1);
      if (state == ST_RD_BUSY)      cnt_last = TW'(T_R_CYC - 1);
      else if (state == ST_PG_BUSY) cnt_last = TW'(T_PROG_CYC - 1);
   end

   always_comb begin
      next_state = state;
      if (cmd_ff) begin
         next_state = ST_RST_BUSY;
      end else if (busy) begin
         if (cnt == cnt_last) next_state = (state == ST_RD_BUSY) ? ST_RD_DATA : ST_IDLE;
      end else if (cmd_cyc) begin
         case (io_s)
            8'h00, 8'h01, 8'h80: next_state = ST_ADDR;
            8'h10:               next_state = (state == ST_PG_DATA) ? ST_PG_BUSY : state;
`ifdef NFC_STATUS_EN
            // Status is an overlay on the current state, so the FSM holds here.
            8'h70: if (!(state == ST_IDLE || state == ST_RD_DATA)) next_state = ST_IDLE;
`endif
            default:             next_state = ST_IDLE;
         endcase
      end else if (addr_cyc && state == ST_ADDR && addr_cnt == 2'd2) begin
         next_state = is_prog ? ST_PG_DATA : ST_RD_BUSY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_s     <= 8'h00;
         cle_s    <= 1'b0;
         ale_s    <= 1'b0;
         wen_s    <= 1'b1;
         wen_p    <= 1'b1;
         ren_s    <= 1'b1;
         ren_p    <= 1'b1;
         state    <= ST_IDLE;
         cnt      <= '0;
         col      <= '0;
         col_hi   <= 1'b0;
         row      <= '0;
         addr_cnt <= 2'd0;
         is_prog  <= 1'b0;
         io_out   <= 8'h00;
         oe       <= 1'b0;
         buf_vld  <= '0;
`ifdef NFC_STATUS_EN
         status_q <= 1'b0;
         fail     <= 1'b0;
`endif
      end else begin
         io_s  <= F_IO_IN;
         cle_s <= F_CLE;
         ale_s <= F_ALE;
         wen_s <= F_WEN;
         wen_p <= wen_s;
         ren_s <= F_REN;
         ren_p <= ren_s;
         state <= next_state;

         if (cmd_ff || next_state != state) cnt <= '0;
         else if (busy)                     cnt <= cnt + TW'(1);

         if (cmd_cyc && !busy) begin
            oe <= 1'b0;
            case (io_s)
               8'h00, 8'h01: begin
                  col_hi   <= io_s[0];
                  is_prog  <= 1'b0;
                  addr_cnt <= 2'd0;
               end
               // Program keeps the column half chosen by a preceding 00h/01h.
               8'h80: begin
                  is_prog  <= 1'b1;
                  addr_cnt <= 2'd0;
                  buf_vld  <= '0;
               end
               default: ;
            endcase
         end
         if (cmd_ff) oe <= 1'b0;

         if (addr_cyc && state == ST_ADDR) begin
            if (addr_cnt == 2'd0)      col <= CW'({7'b0, col_hi, io_s});
            else if (addr_cnt == 2'd1) row <= RW'(io_s);
            else                       row <= RW'({io_s, 8'(row)});
            addr_cnt <= addr_cnt + 2'd1;
         end

         if (data_cyc && state == ST_PG_DATA) begin
            buf_vld[col] <= 1'b1;
            col          <= col + CW'(1);
         end

`ifdef NFC_STATUS_EN
         if (cmd_cyc) status_q <= (io_s == 8'h70) &&
                                  (busy || state == ST_IDLE || state == ST_RD_DATA);
         if (cmd_cyc && !busy && io_s == 8'h10) fail <= (state != ST_PG_DATA);
         if (status_q) begin
            if (ren_fall) begin
               io_out <= status_byte;
               oe     <= 1'b1;
            end else if (ren_rise) begin
               oe <= 1'b0;
            end
         end else
`endif
         if (state == ST_RD_DATA) begin
            if (ren_fall) begin
               io_out <= rd_byte;
               oe     <= 1'b1;
            end else if (ren_rise) begin
               oe  <= 1'b0;
               col <= col + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (data_cyc && state == ST_PG_DATA) buf_dat[col] <= io_s;
   end

   // Programming can only clear bits: stored-inverted OR equals data AND.
   always_ff @(posedge clk) begin
      if (copy_en) mem_n[{row, cp_idx}] <= mem_n[{row, cp_idx}] | ~prog_byte;
   end
endmodule

// File: tb/tb_nfc_flash_responder.sv
// tb/tb_nfc_flash_responder.sv - scoreboard bench for nfc_flash_responder
module tb_nfc_flash_responder;
   localparam int T_R    = 25;
   localparam int T_PROG = 600;
   localparam int T_RST  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] F_IO_IN;
   logic [7:0] F_IO_OUT;
   logic       F_IO_OE;
   logic       F_CLE, F_ALE, F_REN, F_WEN;
   logic       F_RB;

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   logic       rb_after_edge;

   always #5 clk = ~clk;

   nfc_flash_responder dut (
      .clk(clk), .rst(rst), .F_IO_IN(F_IO_IN), .F_IO_OUT(F_IO_OUT), .F_IO_OE(F_IO_OE),
      .F_CLE(F_CLE), .F_ALE(F_ALE), .F_REN(F_REN), .F_WEN(F_WEN), .F_RB(F_RB)
   );

   // Called at a negedge; WEN low 2 clk, high afterwards; returns 2 negedges after the rise.
   task automatic wen_cycle(input logic cle, input logic ale, input logic [7:0] val);
      F_CLE = cle; F_ALE = ale; F_IO_IN = val; F_WEN = 1'b0;
      repeat (2) @(negedge clk);
      F_WEN = 1'b1;
      @(negedge clk);
      rb_after_edge = F_RB;
      @(negedge clk);
      F_CLE = 1'b0; F_ALE = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] c);
      wen_cycle(1'b1, 1'b0, c);
   endtask

   task automatic addr3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
      wen_cycle(1'b0, 1'b1, a0);
      wen_cycle(1'b0, 1'b1, a1);
      wen_cycle(1'b0, 1'b1, a2);
   endtask

   task automatic wr_data(input logic [7:0] d);
      wen_cycle(1'b0, 1'b0, d);
   endtask

   task automatic wait_ready(output int lows);
      lows = 0;
      while (F_RB !== 1'b1 && lows < 2000) begin
         lows++;
         @(negedge clk);
      end
   endtask

   task automatic ren_cycle(output logic [7:0] d, output logic oe_on, output logic oe_off);
      F_REN = 1'b0;
      repeat (2) @(negedge clk);
      d = F_IO_OUT; oe_on = F_IO_OE;
      F_REN = 1'b1;
      repeat (2) @(negedge clk);
      oe_off = F_IO_OE;
   endtask

   task automatic open_read(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input string tag);
      int lows;
      cmd(c);
      addr3(a0, a1, a2);
      tests_run++;
      if (rb_after_edge !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s rb_first_clk: got %b expected 1", tag, rb_after_edge);
      end
      wait_ready(lows);
      tests_run++;
      if (lows != T_R) begin
         tests_failed++;
         $display("FAIL %s rd_busy_len: got %0d expected %0d", tag, lows, T_R);
      end
   endtask

   task automatic prog_confirm(input string tag);
      int lows;
      cmd(8'h10);
      wait_ready(lows);
      tests_run++;
      if (lows != T_PROG) begin
         tests_failed++;
         $display("FAIL %s prog_busy_len: got %0d expected %0d", tag, lows, T_PROG);
      end
   endtask

   task automatic scoreboard_reads(input string tag);
      logic [7:0] d, e;
      logic on, off;
      int n = 0;
      while (exp_q.size() > 0) begin
         ren_cycle(d, on, off);
         e = exp_q.pop_front();
         tests_run++;
         if (d !== e) begin
            tests_failed++;
            $display("FAIL %s byte%0d data: got %02h expected %02h", tag, n, d, e);
         end
         tests_run++;
         if (on !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s byte%0d oe_low: got %b expected 1", tag, n, on);
         end
         tests_run++;
         if (off !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s byte%0d oe_high: got %b expected 0", tag, n, off);
         end
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; F_IO_IN = 8'h00; F_CLE = 0; F_ALE = 0; F_REN = 1; F_WEN = 1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (F_RB !== 1'b1) begin tests_failed++; $display("FAIL reset rb: got %b expected 1", F_RB); end
      tests_run++;
      if (F_IO_OE !== 1'b0) begin tests_failed++; $display("FAIL reset oe: got %b expected 0", F_IO_OE); end
      tests_run++;
      if (F_IO_OUT !== 8'h00) begin tests_failed++; $display("FAIL reset out: got %02h expected 00", F_IO_OUT); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_erased_read();
      open_read(8'h00, 8'h00, 8'h00, 8'h00, "erased");
      for (int i = 0; i < 8; i++) exp_q.push_back(8'hFF);
      scoreboard_reads("erased");
   endtask

   task automatic test_program();
      cmd(8'h80);
      addr3(8'h05, 8'h02, 8'h00);
      wr_data(8'hA5);
      wr_data(8'h3C);
      prog_confirm("program");
      open_read(8'h00, 8'h05, 8'h02, 8'h00, "program_rd");
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF);
      scoreboard_reads("program_rd");
   endtask

   task automatic test_and_rule_and_wrap();
      cmd(8'h80);
      addr3(8'h05, 8'h02, 8'h00);
      wr_data(8'h0F);
      prog_confirm("and_rule");
      open_read(8'h00, 8'h05, 8'h02, 8'h00, "and_rd");
      exp_q.push_back(8'h05); exp_q.push_back(8'h3C);
      scoreboard_reads("and_rd");
      // 01h selects the upper half; 80h programs col 511 then wraps to col 0.
      cmd(8'h01);
      cmd(8'h80);
      addr3(8'hFF, 8'h02, 8'h00);
      wr_data(8'h77);
      wr_data(8'h99);
      prog_confirm("wrap_prog");
      open_read(8'h01, 8'hFF, 8'h02, 8'h00, "wrap_rd");
      exp_q.push_back(8'h77); exp_q.push_back(8'h99);
      scoreboard_reads("wrap_rd");
   endtask

   task automatic test_read_busy();
      logic [7:0] d;
      logic on, off;
      int lows;
      open_read(8'h00, 8'h00, 8'h03, 8'h00, "rd_busy");
      exp_q.push_back(8'hFF);
      scoreboard_reads("rd_busy");
      cmd(8'h00);
      addr3(8'h05, 8'h02, 8'h00);
      ren_cycle(d, on, off);
      tests_run++;
      if (on !== 1'b0 || off !== 1'b0) begin
         tests_failed++;
         $display("FAIL ren_in_busy oe: got %b/%b expected 0/0", on, off);
      end
      wait_ready(lows);
      tests_run++;
      if (lows >= 2000) begin tests_failed++; $display("FAIL ren_in_busy ready: got timeout expected ready"); end
      exp_q.push_back(8'h05);
      scoreboard_reads("ren_in_busy_rd");
   endtask

   task automatic test_abort();
      int lows;
      cmd(8'h00);
      cmd(8'h80);
      addr3(8'h00, 8'h04, 8'h00);
      for (int i = 0; i < 120; i++) wr_data(8'(i));
      cmd(8'h10);
      // FFh is detected in busy cycle 100, so bytes 0..99 are copied.
      repeat (97) @(negedge clk);
      cmd(8'hFF);
      wait_ready(lows);
      tests_run++;
      if (lows != T_RST) begin tests_failed++; $display("FAIL abort rst_busy_len: got %0d expected %0d", lows, T_RST); end
      open_read(8'h00, 8'h62, 8'h04, 8'h00, "abort_rd");
      exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      scoreboard_reads("abort_rd");
   endtask

   task automatic test_reset_mid_read();
      open_read(8'h00, 8'h00, 8'h02, 8'h00, "mid_rst");
      F_REN = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (F_IO_OE !== 1'b1 || F_IO_OUT !== 8'h99) begin
         tests_failed++;
         $display("FAIL mid_rst pre: got oe=%b out=%02h expected oe=1 out=99", F_IO_OE, F_IO_OUT);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (F_IO_OE !== 1'b0 || F_RB !== 1'b1 || F_IO_OUT !== 8'h00) begin
         tests_failed++;
         $display("FAIL mid_rst async: got oe=%b rb=%b out=%02h expected 0/1/00", F_IO_OE, F_RB, F_IO_OUT);
      end
      @(negedge clk);
      F_REN = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      open_read(8'h00, 8'h05, 8'h02, 8'h00, "kept_rd");
      exp_q.push_back(8'h05);
      scoreboard_reads("kept_rd");
   endtask

`ifdef NFC_STATUS_EN
   task automatic test_status();
      int lows;
      cmd(8'h80);
      addr3(8'h00, 8'h05, 8'h00);
      wr_data(8'h11);
      cmd(8'h10);
      cmd(8'h70);
      exp_q.push_back(8'h80);
      scoreboard_reads("status_busy");
      wait_ready(lows);
      exp_q.push_back(8'hC0);
      scoreboard_reads("status_done");
      cmd(8'h10);
      cmd(8'h70);
      exp_q.push_back(8'hC1);
      scoreboard_reads("status_fail");
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_erased_read();
      test_program();
      test_and_rule_and_wrap();
      test_read_busy();
      test_abort();
      test_reset_mid_read();
`ifdef NFC_STATUS_EN
      test_status();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
